sw_mode_ctrl: RTL
=================

Name: sw_mode_ctrl

Overview:
Run/pause/adjust sequencer for the stopwatch counter datapath (SW). Conditions raw PAUSE/ADJ/SEL inputs and holds the mode FSM. Produces single-cycle enable pulses that advance the time counters: 1 Hz count in RUN, 2 Hz field increment in ADJUST. Also drives the display blink. Sits between board inputs and the SW counter/display logic.

Parameters:
TICK_1HZ_DIV, 100000000, clk cycles per cnt_en pulse
TICK_2HZ_DIV, 50000000, clk cycles per adj_inc pulse
BLINK_DIV, 25000000, clk cycles per blink toggle
DEB_CYCLES, 1000000, consecutive stable cycles needed to accept a PAUSE level change

Ports:
clk  in  1  system clock; all logic on rising edge
RESET  in  1  asynchronous, active-high reset
PAUSE  in  1  raw pause pushbutton, asynchronous, bouncy
ADJ  in  1  raw adjust-mode switch, asynchronous
SEL  in  1  raw field select, asynchronous (0 = minutes, 1 = seconds)
cnt_en  out  1  one-cycle pulse: advance stopwatch by one second
adj_inc  out  1  one-cycle pulse: increment the selected field
adj_sel  out  1  registered synchronized SEL; valid while state == ADJUST
blink  out  1  display blank control; 0 outside ADJUST
paused  out  1  saved pause flag
state  out  2  FSM state: RUN = 00, PAUSED = 01, ADJUST = 10

Behaviour:
- Clock and reset (decided): single clock clk; RESET is asynchronous, active-high.
- Reset values while RESET = 1:
  - state = RUN; all outputs 0.
  - All counters, synchronizers and debounce state 0.
  - Applies immediately, including mid-ADJUST or mid-debounce.
- Input synchronization: PAUSE, ADJ and SEL each pass through a 2-flop synchronizer.
- PAUSE debounce:
  - Counter resets whenever the synced value equals the debounced level, or changes during counting.
  - Debounced level takes the synced value once it has differed for DEB_CYCLES consecutive cycles.
  - A rising edge of the debounced level gives press_pulse for 1 cycle.
  - Raw press edge to FSM reaction = 2 + DEB_CYCLES + 1 cycles.
  - ADJ and SEL are synchronized only, not debounced.
- FSM transitions, priority top-down:
  - RUN, adj_s = 1 -> ADJUST; paused kept 0.
  - PAUSED, adj_s = 1 -> ADJUST; paused kept 1.
  - RUN, press_pulse -> PAUSED; paused = 1.
  - PAUSED, press_pulse -> RUN; paused = 0.
  - ADJUST, adj_s = 0 -> PAUSED if paused = 1, else RUN.
  - ADJUST, press_pulse -> ignored and dropped; paused unchanged.
  - press_pulse in the same cycle as an adj_s rise -> ADJUST wins; press dropped.
- 1 Hz divider (0..TICK_1HZ_DIV-1):
  - Increments only in RUN; holds its value in PAUSED and ADJUST.
  - cnt_en = 1 for the cycle the count == TICK_1HZ_DIV-1; count then wraps to 0.
  - First cnt_en after reset release is on cycle TICK_1HZ_DIV.
  - cnt_en is never asserted outside RUN.
- 2 Hz divider:
  - Cleared on every entry to ADJUST; runs only in ADJUST.
  - adj_inc pulses on wrap, first pulse TICK_2HZ_DIV cycles after entry.
- adj_sel: updated from synced SEL every cycle in ADJUST; held otherwise. A SEL change takes effect on the next adj_inc.
- Blink:
  - On ADJUST entry, blink = 1 and the blink counter clears.
  - Toggles every BLINK_DIV cycles.
  - Forced to 0 in the cycle the FSM leaves ADJUST.
- Widths: each divider counter is $clog2(DIV) bits.
- Divider parameters are >= 2; values below 2 are unsupported.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
SW_TICK_PHASE_RESET_EN
- Defined: the 1 Hz divider clears on every entry to RUN (from PAUSED or ADJUST). The first cnt_en after resume is exactly TICK_1HZ_DIV cycles later.
- Undefined: the divider holds its partial count across PAUSED/ADJUST. The first cnt_en after resume arrives after the remaining partial period.

Test Plan:
All scenarios use TICK_1HZ_DIV=10, TICK_2HZ_DIV=5, BLINK_DIV=3, DEB_CYCLES=4.
1. Release RESET, hold inputs 0 -> cnt_en pulses at cycles 10, 20, 30; state = 00; adj_inc = blink = 0.
2. Pause and resume (macro undefined):
   - 3 cycles after a cnt_en, raise PAUSE for 8 cycles -> paused = 1 and state = 01 exactly 7 cycles after the edge; no cnt_en while paused.
   - Second identical press -> state = 00; first cnt_en arrives 10 - (3+7) = 0 remaining + held phase.
   - With SW_TICK_PHASE_RESET_EN defined, first cnt_en is exactly 10 cycles after resume.
3. PAUSE high for 3 cycles, then low (glitch) -> no press_pulse; state and paused unchanged.
4. Adjust entry and exit:
   - In RUN, ADJ = 1, SEL = 0 -> state = 10 three cycles later; blink = 1 and toggles every 3 cycles; adj_inc every 5 cycles with adj_sel = 0; cnt_en = 0.
   - Set SEL = 1 -> next adj_inc has adj_sel = 1.
   - ADJ = 0 -> state = 00; blink = 0.
5. Pause press during ADJUST:
   - From PAUSED, enter ADJUST and give a debounced PAUSE press -> paused stays 1.
   - ADJ = 0 -> state = 01.
6. Assert RESET mid-ADJUST with blink = 1 -> outputs go to 0 and state = 00 without waiting for a clock edge.
   - After release, behaviour matches scenario 1.

Source files
------------

// File: rtl/sw_mode_ctrl.sv
// Stopwatch run/pause/adjust sequencer: input conditioning, mode FSM, tick dividers and blink.
// Optional macro SW_TICK_PHASE_RESET_EN restarts the 1 Hz phase on every entry to RUN.
module sw_mode_ctrl #(
    parameter int TICK_1HZ_DIV = 100000000,
    parameter int TICK_2HZ_DIV = 50000000,
    parameter int BLINK_DIV    = 25000000,
    parameter int DEB_CYCLES   = 1000000
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       PAUSE,
    input  logic       ADJ,
    input  logic       SEL,
    output logic       cnt_en,
    output logic       adj_inc,
    output logic       adj_sel,
    output logic       blink,
    output logic       paused,
    output logic [1:0] state
);

    localparam int W1 = $clog2(TICK_1HZ_DIV);
    localparam int W2 = $clog2(TICK_2HZ_DIV);
    localparam int WB = $clog2(BLINK_DIV);
    localparam int WD = $clog2(DEB_CYCLES);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        PAUSED = 2'b01,
        ADJUST = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic paused_q, paused_d;
    logic pause_m_q, pause_m_d, pause_s_q, pause_s_d;
    logic adj_m_q, adj_m_d, adj_s_q, adj_s_d;
    logic sel_m_q, sel_m_d, sel_s_q, sel_s_d;
    logic deb_q, deb_d, press_q, press_d;
    logic [WD-1:0] deb_cnt_q, deb_cnt_d;
    logic [W1-1:0] cnt1_q, cnt1_d;
    logic [W2-1:0] cnt2_q, cnt2_d;
    logic [WB-1:0] blink_cnt_q, blink_cnt_d;
    logic cnt_en_q, cnt_en_d, adj_inc_q, adj_inc_d;
    logic blink_q, blink_d, adj_sel_q, adj_sel_d;
    logic run_stay, adj_stay, adj_entry;

    // Mode FSM; ADJ has priority over a coincident press, and presses in ADJUST are dropped.
    always_comb begin
        state_d  = state_q;
        paused_d = paused_q;
        case (state_q)
            RUN: begin
                if (adj_s_q) begin
                    state_d = ADJUST;
                end else if (press_q) begin
                    state_d  = PAUSED;
                    paused_d = 1'b1;
                end
            end
            PAUSED: begin
                if (adj_s_q) begin
                    state_d = ADJUST;
                end else if (press_q) begin
                    state_d  = RUN;
                    paused_d = 1'b0;
                end
            end
            ADJUST: begin
                if (!adj_s_q) state_d = paused_q ? PAUSED : RUN;
            end
            default: begin
                state_d  = RUN;
                paused_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        pause_m_d = PAUSE;
        pause_s_d = pause_m_q;
        adj_m_d   = ADJ;
        adj_s_d   = adj_m_q;
        sel_m_d   = SEL;
        sel_s_d   = sel_m_q;

        deb_d     = deb_q;
        deb_cnt_d = '0;
        press_d   = 1'b0;
        if (pause_s_q != deb_q) begin
            if (deb_cnt_q == WD'(DEB_CYCLES - 1)) begin
                deb_d   = pause_s_q;
                press_d = pause_s_q;
            end else begin
                deb_cnt_d = deb_cnt_q + WD'(1);
            end
        end

        // Dividers only advance when the mode is stable across the edge, so a tick never
        // lands in the cycle the FSM leaves its mode.
        run_stay  = (state_q == RUN) && (state_d == RUN);
        adj_stay  = (state_q == ADJUST) && (state_d == ADJUST);
        adj_entry = (state_q != ADJUST) && (state_d == ADJUST);

        cnt1_d   = cnt1_q;
        cnt_en_d = 1'b0;
        if (run_stay) begin
            if (cnt1_q == W1'(TICK_1HZ_DIV - 1)) begin
                cnt1_d   = '0;
                cnt_en_d = 1'b1;
            end else begin
                cnt1_d = cnt1_q + W1'(1);
            end
        end
`ifdef SW_TICK_PHASE_RESET_EN
        if ((state_q != RUN) && (state_d == RUN)) cnt1_d = '0;
`endif

        cnt2_d    = cnt2_q;
        adj_inc_d = 1'b0;
        if (adj_entry) begin
            cnt2_d = '0;
        end else if (adj_stay) begin
            if (cnt2_q == W2'(TICK_2HZ_DIV - 1)) begin
                cnt2_d    = '0;
                adj_inc_d = 1'b1;
            end else begin
                cnt2_d = cnt2_q + W2'(1);
            end
        end

        blink_d     = 1'b0;
        blink_cnt_d = blink_cnt_q;
        if (adj_entry) begin
            blink_d     = 1'b1;
            blink_cnt_d = '0;
        end else if (adj_stay) begin
            blink_d = blink_q;
            if (blink_cnt_q == WB'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + WB'(1);
            end
        end

        adj_sel_d = (state_d == ADJUST) ? sel_s_q : adj_sel_q;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q     <= RUN;
            paused_q    <= 1'b0;
            pause_m_q   <= 1'b0;
            pause_s_q   <= 1'b0;
            adj_m_q     <= 1'b0;
            adj_s_q     <= 1'b0;
            sel_m_q     <= 1'b0;
            sel_s_q     <= 1'b0;
            deb_q       <= 1'b0;
            deb_cnt_q   <= '0;
            press_q     <= 1'b0;
            cnt1_q      <= '0;
            cnt_en_q    <= 1'b0;
            cnt2_q      <= '0;
            adj_inc_q   <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            adj_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paused_q    <= paused_d;
            pause_m_q   <= pause_m_d;
            pause_s_q   <= pause_s_d;
            adj_m_q     <= adj_m_d;
            adj_s_q     <= adj_s_d;
            sel_m_q     <= sel_m_d;
            sel_s_q     <= sel_s_d;
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
            press_q     <= press_d;
            cnt1_q      <= cnt1_d;
            cnt_en_q    <= cnt_en_d;
            cnt2_q      <= cnt2_d;
            adj_inc_q   <= adj_inc_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            adj_sel_q   <= adj_sel_d;
        end
    end

    assign cnt_en  = cnt_en_q;
    assign adj_inc = adj_inc_q;
    assign adj_sel = adj_sel_q;
    assign blink   = blink_q;
    assign paused  = paused_q;
    assign state   = state_q;

endmodule
